// File: rtl/bus_term_ctrl.sv
// bus_term_ctrl: merges the per-peripheral active-low DSACK pairs into the CPU
// nDSACK pair and terminates cycles that nobody acknowledges with a bus error.
// Optional feature macro: BUS_WATCHDOG_EN builds the timeout counter, the BERR
// state and the sticky error flag. Without it WAIT waits for an ack or nAS
// negation indefinitely, nBerr stays 1 and errFlag stays 0.
module bus_term_ctrl #(
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 250
) (
    input  logic                 sysClk,
    input  logic                 nReset,
    input  logic                 nAS,
    input  logic [2*NUM_SRC-1:0] nDsackSrc,
    input  logic                 clrErr,
    output logic [1:0]           nDsack,
    output logic                 nBerr,
    output logic                 errFlag,
    output logic [1:0]           cycState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        BERR = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] dsack_q, dsack_d;
    logic       berr_n_q, berr_n_d;
    logic [1:0] combined;

`ifdef BUS_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    // Timeout and clear inputs have no function when the watchdog is absent.
    localparam int unused_timeout = TIMEOUT_CYCLES;
    logic unused_clr;
    assign unused_clr = clrErr;
`endif

    // Wired-AND merge: a DSACK bit is asserted if any source pulls it low.
    always_comb begin
        combined = 2'b11;
        for (int i = 0; i < NUM_SRC; i++) begin
            combined[0] = combined[0] & nDsackSrc[2*i];
            combined[1] = combined[1] & nDsackSrc[2*i+1];
        end
    end

    // Next-state and next-output logic for the termination FSM.
    always_comb begin
        state_d  = state_q;
        dsack_d  = dsack_q;
        berr_n_d = berr_n_q;
`ifdef BUS_WATCHDOG_EN
        // Counter only advances while waiting; every other path clears it.
        cnt_d    = '0;
        // Clear first so a same-edge BERR entry below overrides it.
        err_d    = clrErr ? 1'b0 : err_q;
`endif
        case (state_q)
            IDLE: begin
                dsack_d  = 2'b11;
                berr_n_d = 1'b1;
                if (!nAS) state_d = WAIT;
            end
            WAIT: begin
                if (nAS) begin
                    // Aborted cycle: leave without terminating.
                    state_d = IDLE;
                end else if (combined != 2'b11) begin
                    // Ack beats a coincident timeout.
                    state_d = ACK;
                    dsack_d = combined;
`ifdef BUS_WATCHDOG_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = BERR;
                    berr_n_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`endif
                end
            end
            ACK: begin
                // Latched DSACK holds until the CPU negates address strobe.
                if (nAS) begin
                    state_d = IDLE;
                    dsack_d = 2'b11;
                end
            end
`ifdef BUS_WATCHDOG_EN
            BERR: begin
                // Late DSACKs are ignored; only nAS negation ends the cycle.
                dsack_d = 2'b11;
                if (nAS) begin
                    state_d  = IDLE;
                    berr_n_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d  = IDLE;
                dsack_d  = 2'b11;
                berr_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge sysClk) begin
        if (!nReset) begin
            state_q  <= IDLE;
            dsack_q  <= 2'b11;
            berr_n_q <= 1'b1;
`ifdef BUS_WATCHDOG_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dsack_q  <= dsack_d;
            berr_n_q <= berr_n_d;
`ifdef BUS_WATCHDOG_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign nDsack   = dsack_q;
    assign nBerr    = berr_n_q;
    assign cycState = state_q;
`ifdef BUS_WATCHDOG_EN
    assign errFlag  = err_q;
`else
    assign errFlag  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_term_ctrl.sv
// Directed bench for bus_term_ctrl (NUM_SRC=4, TIMEOUT_CYCLES=16). A vector
// table covers reset, ack, abort and merge; hand sequences cover timeout,
// ack/timeout race, clear/set collision and the watchdog-less long wait.
module tb_bus_term_ctrl;

    localparam int NSRC = 4;
    localparam int TO   = 16;

    logic            sysClk = 1'b0;
    logic            nReset = 1'b0;
    logic            nAS    = 1'b1;
    logic [2*NSRC-1:0] nDsackSrc = '1;
    logic            clrErr = 1'b0;
    logic [1:0]      nDsack;
    logic            nBerr;
    logic            errFlag;
    logic [1:0]      cycState;

    int errors = 0;
    int checks = 0;

    bus_term_ctrl #(.NUM_SRC(NSRC), .TIMEOUT_CYCLES(TO)) dut (
        .sysClk(sysClk), .nReset(nReset), .nAS(nAS), .nDsackSrc(nDsackSrc),
        .clrErr(clrErr), .nDsack(nDsack), .nBerr(nBerr), .errFlag(errFlag),
        .cycState(cycState)
    );

    always #5 sysClk = ~sysClk;

    typedef struct {
        logic       rst_n;
        logic       as_n;
        logic       clr;
        logic [7:0] src;
        logic [1:0] e_dsack;
        logic       e_berr;
        logic       e_err;
        logic [1:0] e_st;
    } vec_t;

    vec_t tbl[21];

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk(input string nm, input logic [1:0] ed, input logic eb,
                       input logic ee, input logic [1:0] es);
        cmp({nm, ".nDsack"},   int'(nDsack),   int'(ed));
        cmp({nm, ".nBerr"},    int'(nBerr),    int'(eb));
        cmp({nm, ".errFlag"},  int'(errFlag),  int'(ee));
        cmp({nm, ".cycState"}, int'(cycState), int'(es));
    endtask

    // Drive inputs, let one rising edge sample them, then settle to the falling edge.
    task automatic tick(input logic rst_n, input logic as_n, input logic [7:0] src,
                        input logic clr);
        nReset    = rst_n;
        nAS       = as_n;
        nDsackSrc = src;
        clrErr    = clr;
        @(posedge sysClk);
        @(negedge sysClk);
    endtask

    logic ok;
    logic e_wd_berr, e_wd_err;
    logic [1:0] e_wd_st;

    initial begin
        //           rst  nAS  clr  src    dsack  berr err  state
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd0}; // reset
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1}; // strobe
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'hFE, 2'b10, 1'b1, 1'b0, 2'd2}; // src0 ack
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'hFE, 2'b11, 1'b1, 1'b0, 2'd0}; // reset in ACK
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1}; // E0
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'hEF, 2'b10, 1'b1, 1'b0, 2'd2}; // src2 ack
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'hFD, 2'b10, 1'b1, 1'b0, 2'd2}; // latched
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd0}; // release
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd0}; // abort
        tbl[17] = '{1'b1, 1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd1};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 8'h7E, 2'b00, 1'b1, 1'b0, 2'd2}; // merge 0+3
        tbl[19] = '{1'b1, 1'b1, 1'b0, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd0};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 8'hFF, 2'b11, 1'b1, 1'b0, 2'd0};

        for (int i = 0; i < 21; i++) begin
            tick(tbl[i].rst_n, tbl[i].as_n, tbl[i].src, tbl[i].clr);
            chk($sformatf("vec%0d", i), tbl[i].e_dsack, tbl[i].e_berr,
                tbl[i].e_err, tbl[i].e_st);
        end

`ifdef BUS_WATCHDOG_EN
        e_wd_berr = 1'b0; e_wd_err = 1'b1; e_wd_st = 2'd3;
`else
        e_wd_berr = 1'b1; e_wd_err = 1'b0; e_wd_st = 2'd1;
`endif

        // Timeout: strobe sampled at E0, nBerr expected at E0+TO.
        tick(1'b1, 1'b0, 8'hFF, 1'b0);
        ok = 1'b1;
        for (int k = 1; k < TO; k++) begin
            tick(1'b1, 1'b0, 8'hFF, 1'b0);
            if (nBerr !== 1'b1 || cycState !== 2'd1) ok = 1'b0;
        end
        cmp("to.early_wait", int'(ok), 1);
        tick(1'b1, 1'b0, 8'hFF, 1'b0);
        chk("to.edge", 2'b11, e_wd_berr, e_wd_err, e_wd_st);
        // Late source 1 ack.
        tick(1'b1, 1'b0, 8'hF7, 1'b0);
`ifdef BUS_WATCHDOG_EN
        chk("to.late_ack", 2'b11, 1'b0, 1'b1, 2'd3);
`else
        chk("to.late_ack", 2'b01, 1'b1, 1'b0, 2'd2);
`endif
        tick(1'b1, 1'b1, 8'hFF, 1'b0);
        chk("to.release", 2'b11, 1'b1, e_wd_err, 2'd0);
        tick(1'b1, 1'b1, 8'hFF, 1'b1);
        chk("to.clear", 2'b11, 1'b1, 1'b0, 2'd0);
        tick(1'b1, 1'b1, 8'hFF, 1'b0);

        // Race: ack arrives at the same edge the timeout would fire.
        tick(1'b1, 1'b0, 8'hFF, 1'b0);
        for (int k = 1; k < TO; k++) tick(1'b1, 1'b0, 8'hFF, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        chk("race", 2'b00, 1'b1, 1'b0, 2'd2);
        tick(1'b1, 1'b1, 8'hFF, 1'b0);
        chk("race.release", 2'b11, 1'b1, 1'b0, 2'd0);

        // Clear pulse coincident with BERR entry: set wins.
        tick(1'b1, 1'b0, 8'hFF, 1'b0);
        for (int k = 1; k < TO; k++) tick(1'b1, 1'b0, 8'hFF, 1'b0);
        tick(1'b1, 1'b0, 8'hFF, 1'b1);
        chk("setwins", 2'b11, e_wd_berr, e_wd_err, e_wd_st);
        tick(1'b1, 1'b0, 8'hFF, 1'b0);
        cmp("setwins.hold", int'(errFlag), int'(e_wd_err));
        tick(1'b1, 1'b1, 8'hFF, 1'b0);
        cmp("setwins.release", int'(nBerr), 1);

`ifndef BUS_WATCHDOG_EN
        // Without the watchdog a strobed cycle waits indefinitely.
        tick(1'b1, 1'b1, 8'hFF, 1'b1);
        tick(1'b1, 1'b0, 8'hFF, 1'b0);
        ok = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick(1'b1, 1'b0, 8'hFF, 1'b0);
            if (nBerr !== 1'b1 || cycState !== 2'd1 || errFlag !== 1'b0) ok = 1'b0;
        end
        cmp("nowd.longwait", int'(ok), 1);
        tick(1'b1, 1'b0, 8'hFE, 1'b0);
        chk("nowd.ack", 2'b10, 1'b1, 1'b0, 2'd2);
        tick(1'b1, 1'b1, 8'hFF, 1'b0);
        chk("nowd.release", 2'b11, 1'b1, 1'b0, 2'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
